// File: rtl/motor_json_tx.sv
// ---------------------------------------------------------------------------
// motor_json_tx
//
// Motor command link for the robot drive base. A one-hot motor command is
// decoded into signed left/right wheel speeds. The speeds are sent as a
// fixed 26-byte JSON frame on a built-in 8N1 UART transmitter:
//
//   {"T":1,"L":FFFF,"R":FFFF}\n
//
// Each FFFF field is a signed decimal value, right-justified in four
// characters and padded with leading spaces.
//
// Frames repeat on a period of PERIOD_MS milliseconds. A tick that arrives
// while a frame is in flight is remembered as a single pending request.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per UART bit
//   CLKS_PER_MS  : clock cycles per millisecond
//   PERIOD_MS    : frame start-to-start period in ms (PERIOD_MS*CLKS_PER_MS >= 1)
//   SPEED        : wheel speed magnitude for motion commands (0..255)
//
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   motor_cmd  : one-hot command [0] fwd, [1] back, [2] left, [3] right, [4] stop
//   tx_en      : frame-start enable; never aborts a frame in progress
//   uart_out   : UART TX line, idle high
//   busy       : high from the first start bit through the last stop bit
//   frame_done : one-cycle pulse after the last stop bit of a frame
//   cmd_err    : one-cycle pulse when a multi-hot command is latched
//
// Optional feature macro: MOTOR_TX_ONCHANGE_EN
//   When defined, any change of motor_cmd away from the command of the most
//   recently started frame also requests a frame (while tx_en=1). The period
//   timer is unaffected by these requests.
// ---------------------------------------------------------------------------
module motor_json_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CLKS_PER_MS  = 50000,
  parameter int PERIOD_MS    = 200,
  parameter int SPEED        = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] motor_cmd,
  input  logic       tx_en,
  output logic       uart_out,
  output logic       busy,
  output logic       frame_done,
  output logic       cmd_err
);

  // Builds the 4-character speed field at elaboration time.
  // The first character of the field is placed in bits [31:24].
  function automatic logic [31:0] speed_field(input int mag, input logic neg);
    logic [7:0] sign_c;
    logic [7:0] d_h;
    logic [7:0] d_t;
    logic [7:0] d_o;
    sign_c = neg ? 8'h2D : 8'h20;
    d_h    = 8'h30 + 8'(mag / 100);
    d_t    = 8'h30 + 8'((mag / 10) % 10);
    d_o    = 8'h30 + 8'(mag % 10);
    if (mag == 0) begin
      speed_field = {8'h20, 8'h20, 8'h20, 8'h30};
    end else if (mag >= 100) begin
      speed_field = {sign_c, d_h, d_t, d_o};
    end else if (mag >= 10) begin
      speed_field = {8'h20, sign_c, d_t, d_o};
    end else begin
      speed_field = {8'h20, 8'h20, sign_c, d_o};
    end
  endfunction

  localparam int PERIOD_CYC = PERIOD_MS * CLKS_PER_MS;
  localparam int TMR_W      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int BIT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(PERIOD_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]       LAST_BYTE = 5'd25;

  localparam logic [31:0] FIELD_POS  = speed_field(SPEED, 1'b0);
  localparam logic [31:0] FIELD_NEG  = speed_field(SPEED, 1'b1);
  localparam logic [31:0] FIELD_ZERO = {8'h20, 8'h20, 8'h20, 8'h30};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic               tick;
  logic               pending;
  logic [4:0]         cmd_q;
  logic [BIT_W-1:0]   bit_cnt;
  logic [2:0]         bit_idx;
  logic [4:0]         byte_idx;
  logic [7:0]         shift_q;
  logic [7:0]         frame_byte;
  logic [31:0]        l_field;
  logic [31:0]        r_field;
  logic               multi_hot;
  logic               change_req;
  logic               frame_req;
  logic               start_now;
  logic               bit_end;
  logic               in_frame;

  // Free-running period timer. It wraps instead of saturating, and a tick
  // is the cycle in which the timer reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (timer == TMR_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign tick = (timer == '0);

`ifdef MOTOR_TX_ONCHANGE_EN
  // Command of the most recently started frame. The reset value is "stop",
  // so any motion command present after reset counts as a change.
  logic [4:0] last_sent;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_sent <= 5'b10000;
    end else if (start_now) begin
      last_sent <= motor_cmd;
    end
  end

  assign change_req = (motor_cmd != last_sent);
`else
  assign change_req = 1'b0;
`endif

  // A command with more than one bit set: clearing the lowest set bit
  // leaves something behind.
  assign multi_hot = ((motor_cmd & (motor_cmd - 5'd1)) != 5'd0);
  assign frame_req = tick | change_req;
  assign bit_end   = (bit_cnt == BIT_LAST);
  assign in_frame  = (state == S_START) || (state == S_DATA) || (state == S_STOP);

  // A frame may start from IDLE, or directly from the DONE cycle. Starting
  // from DONE lets back-to-back frames follow one cycle after frame_done.
  assign start_now = ((state == S_IDLE) || (state == S_DONE)) &&
                     tx_en && (frame_req || pending);

  // Wheel speeds from the latched command.
  // Stop, no command and multi-hot commands all give zero speeds.
  always_comb begin
    l_field = FIELD_ZERO;
    r_field = FIELD_ZERO;
    case (cmd_q)
      5'b00001: begin l_field = FIELD_POS; r_field = FIELD_POS; end
      5'b00010: begin l_field = FIELD_NEG; r_field = FIELD_NEG; end
      5'b00100: begin l_field = FIELD_NEG; r_field = FIELD_POS; end
      5'b01000: begin l_field = FIELD_POS; r_field = FIELD_NEG; end
      default:  begin l_field = FIELD_ZERO; r_field = FIELD_ZERO; end
    endcase
  end

  // Frame text: fixed punctuation plus the two speed fields.
  always_comb begin
    frame_byte = 8'h20;
    case (byte_idx)
      5'd0:    frame_byte = 8'h7B;
      5'd1:    frame_byte = 8'h22;
      5'd2:    frame_byte = 8'h54;
      5'd3:    frame_byte = 8'h22;
      5'd4:    frame_byte = 8'h3A;
      5'd5:    frame_byte = 8'h31;
      5'd6:    frame_byte = 8'h2C;
      5'd7:    frame_byte = 8'h22;
      5'd8:    frame_byte = 8'h4C;
      5'd9:    frame_byte = 8'h22;
      5'd10:   frame_byte = 8'h3A;
      5'd11:   frame_byte = l_field[31:24];
      5'd12:   frame_byte = l_field[23:16];
      5'd13:   frame_byte = l_field[15:8];
      5'd14:   frame_byte = l_field[7:0];
      5'd15:   frame_byte = 8'h2C;
      5'd16:   frame_byte = 8'h22;
      5'd17:   frame_byte = 8'h52;
      5'd18:   frame_byte = 8'h22;
      5'd19:   frame_byte = 8'h3A;
      5'd20:   frame_byte = r_field[31:24];
      5'd21:   frame_byte = r_field[23:16];
      5'd22:   frame_byte = r_field[15:8];
      5'd23:   frame_byte = r_field[7:0];
      5'd24:   frame_byte = 8'h7D;
      5'd25:   frame_byte = 8'h0A;
      default: frame_byte = 8'h20;
    endcase
  end

  // Transmit FSM with registered line and status outputs.
  // Each START/DATA/STOP bit lasts CLKS_PER_BIT cycles. The next level is
  // loaded at the bit boundary, so bytes run back to back with no idle gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pending    <= 1'b0;
      cmd_q      <= '0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shift_q    <= '0;
      uart_out   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          uart_out <= 1'b1;
          busy     <= 1'b0;
          if (start_now) begin
            cmd_q    <= motor_cmd;
            cmd_err  <= multi_hot;
            pending  <= 1'b0;
            byte_idx <= '0;
            bit_cnt  <= '0;
            uart_out <= 1'b0;
            busy     <= 1'b1;
            state    <= S_START;
          end else begin
            state <= S_IDLE;
          end
        end

        S_START: begin
          if (bit_end) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift_q  <= frame_byte;
            uart_out <= frame_byte[0];
            state    <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_out <= 1'b1;
              state    <= S_STOP;
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              shift_q  <= {1'b0, shift_q[7:1]};
              uart_out <= shift_q[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              uart_out   <= 1'b1;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              uart_out <= 1'b0;
              state    <= S_START;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          uart_out <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase

      // Requests that arrive mid-frame collapse into one pending flag.
      // Requests that arrive while tx_en is low are dropped.
      if (in_frame && tx_en && frame_req) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_motor_json_tx.sv
// ---------------------------------------------------------------------------
// tb_motor_json_tx
//
// Bench for motor_json_tx. It uses two instances that share all inputs:
//   dut_slow : 2000-cycle period
//   dut_fast : 10-cycle period, for back-to-back framing
//
// Both instances use 4 cycles per UART bit. The expected frame text comes
// from a printf-style model of the JSON line. UART capture checks bit
// timing, busy, frame_done and cmd_err across the whole frame.
// ---------------------------------------------------------------------------
module tb_motor_json_tx;

  localparam int CPB       = 4;
  localparam int CPM       = 10;
  localparam int SPEED     = 100;
  localparam int PERIOD    = 2000;
  localparam int FRAME_CYC = 26 * 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] motor_cmd = 5'b00000;
  logic       tx_en = 1'b0;

  logic uart_s, busy_s, done_s, err_s;
  logic uart_f, busy_f, done_f, err_f;

  motor_json_tx #(.CLKS_PER_BIT(CPB), .CLKS_PER_MS(CPM), .PERIOD_MS(200), .SPEED(SPEED)) dut_slow (
    .clk(clk), .reset(reset), .motor_cmd(motor_cmd), .tx_en(tx_en),
    .uart_out(uart_s), .busy(busy_s), .frame_done(done_s), .cmd_err(err_s));

  motor_json_tx #(.CLKS_PER_BIT(CPB), .CLKS_PER_MS(CPM), .PERIOD_MS(1), .SPEED(SPEED)) dut_fast (
    .clk(clk), .reset(reset), .motor_cmd(motor_cmd), .tx_en(tx_en),
    .uart_out(uart_f), .busy(busy_f), .frame_done(done_f), .cmd_err(err_f));

  always #5 clk = ~clk;

  // Cycle counter; rel0 marks the release of reset, so cyc-rel0 is the
  // cycle number counted from the release.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rel0 = 0;
  bit sel = 1'b0;
  int errors = 0;
  int checks = 0;

  logic mon_uart, mon_busy, mon_done, mon_err;
  assign mon_uart = sel ? uart_f : uart_s;
  assign mon_busy = sel ? busy_f : busy_s;
  assign mon_done = sel ? done_f : done_s;
  assign mon_err  = sel ? err_f  : err_s;

  // Results of the most recent frame capture.
  logic  samples [FRAME_CYC];
  string cap_str;
  int    cap_st;
  bit    cap_found, cap_timing_ok, cap_busy_ok, cap_fd_mid;
  logic  cap_err_first, cap_fd_end, cap_busy_end;
  int    cap_err_cnt;

  // Reference model: the frame text built from the command rules.
  function automatic string model_frame(input logic [4:0] cmd);
    int l, r;
    l = 0;
    r = 0;
    if ($countones(cmd) == 1) begin
      if (cmd[0]) begin l =  SPEED; r =  SPEED; end
      if (cmd[1]) begin l = -SPEED; r = -SPEED; end
      if (cmd[2]) begin l = -SPEED; r =  SPEED; end
      if (cmd[3]) begin l =  SPEED; r = -SPEED; end
    end
    return $sformatf("{\"T\":1,\"L\":%4d,\"R\":%4d}\n", l, r);
  endfunction

  function automatic int model_err(input logic [4:0] cmd);
    return ($countones(cmd) > 1) ? 1 : 0;
  endfunction

  // Printable form of a frame, with the trailing newline escaped.
  function automatic string vis(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0A) r = {r, "\\n"};
      else               r = {r, $sformatf("%c", s[i])};
    end
    return r;
  endfunction

  task automatic do_reset(input logic [4:0] cmd, input logic en);
    @(negedge clk);
    reset = 1'b1;
    motor_cmd = cmd;
    tx_en = en;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rel0 = cyc;
  endtask

  task automatic wait_until(input int rel_cycle, output bit idle_ok);
    idle_ok = 1'b1;
    while ((cyc - rel0) < rel_cycle) begin
      @(negedge clk);
      if (mon_uart !== 1'b1 || mon_busy !== 1'b0) idle_ok = 1'b0;
    end
  endtask

  // Waits (bounded) for a start bit, then records the whole frame.
  // tx_en and motor_cmd may be changed at chosen sample indices.
  task automatic capture(input int limit, input int en_at, input logic en_val,
                         input int chg_at, input logic [4:0] chg_cmd);
    int n;
    int base;
    logic [7:0] b;
    logic v;
    cap_found = 1'b0; cap_str = ""; cap_st = -1; cap_timing_ok = 1'b1;
    cap_busy_ok = 1'b1; cap_fd_mid = 1'b0; cap_err_cnt = 0; cap_err_first = 1'bx;
    cap_fd_end = 1'bx; cap_busy_end = 1'bx;
    n = 0;
    while (!cap_found && n < limit) begin
      @(negedge clk);
      n++;
      if (mon_uart === 1'b0) cap_found = 1'b1;
    end
    if (cap_found) begin
      cap_st = cyc - rel0;
      for (int i = 0; i < FRAME_CYC; i++) begin
        if (i > 0) @(negedge clk);
        samples[i] = mon_uart;
        if (mon_busy !== 1'b1) cap_busy_ok = 1'b0;
        if (mon_done !== 1'b0) cap_fd_mid = 1'b1;
        if (mon_err === 1'b1) cap_err_cnt++;
        if (i == 0) cap_err_first = mon_err;
        if (i == en_at) tx_en = en_val;
        if (i == chg_at) motor_cmd = chg_cmd;
      end
      @(negedge clk);
      cap_fd_end = mon_done;
      cap_busy_end = mon_busy;
      if (mon_err === 1'b1) cap_err_cnt++;
      for (int by = 0; by < 26; by++) begin
        b = 8'h00;
        for (int k = 0; k < 10; k++) begin
          base = (by * 10 + k) * CPB;
          v = samples[base];
          for (int j = 1; j < CPB; j++) if (samples[base + j] !== v) cap_timing_ok = 1'b0;
          if (k == 0 && v !== 1'b0) cap_timing_ok = 1'b0;
          if (k == 9 && v !== 1'b1) cap_timing_ok = 1'b0;
          if (k >= 1 && k <= 8) b[k-1] = v;
        end
        cap_str = {cap_str, $sformatf("%c", b)};
      end
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tx_en = 1'b1;
    motor_cmd = 5'b00001;
    repeat (2) @(negedge clk);
    checks++; if (uart_s !== 1'b1) begin errors++; $display("[TB] FAIL reset_uart: got %b expected 1", uart_s); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_s); end
    checks++; if (done_s !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done_s); end
    checks++; if (err_s  !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err_s); end
    checks++; if (uart_f !== 1'b1) begin errors++; $display("[TB] FAIL reset_uart_fast: got %b expected 1", uart_f); end
    checks++; if (busy_f !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_fast: got %b expected 0", busy_f); end
  endtask

  task automatic test_basic();
    string exp;
    sel = 1'b0;
    exp = model_frame(5'b00001);
    do_reset(5'b00001, 1'b1);
    capture(20, -1, 1'b0, -1, 5'b0);
    checks++; if (cap_st !== 1) begin errors++; $display("[TB] FAIL basic_start: got cycle %0d expected 1", cap_st); end
    checks++; if (cap_str != exp) begin errors++; $display("[TB] FAIL basic_text: got '%s' expected '%s'", vis(cap_str), vis(exp)); end
    checks++; if (cap_timing_ok !== 1'b1) begin errors++; $display("[TB] FAIL basic_bit_timing: got %b expected 1", cap_timing_ok); end
    checks++; if (cap_busy_ok !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 1", cap_busy_ok); end
    checks++; if (cap_fd_mid !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_early: got %b expected 0", cap_fd_mid); end
    checks++; if (cap_fd_end !== 1'b1) begin errors++; $display("[TB] FAIL basic_done_1041: got %b expected 1", cap_fd_end); end
    checks++; if (cap_busy_end !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_1041: got %b expected 0", cap_busy_end); end
    checks++; if (cap_err_cnt !== 0) begin errors++; $display("[TB] FAIL basic_cmd_err: got %0d expected 0", cap_err_cnt); end
  endtask

  // Directed left-turn and multi-hot cases, then random commands. The random
  // commands also change motor_cmd mid-frame to confirm the latched copy is used.
  task automatic test_decode();
    logic [4:0] cmd;
    string exp;
    int chg_at;
    sel = 1'b0;
    for (int it = 0; it < 8; it++) begin
      chg_at = -1;
      if (it == 0)      cmd = 5'b00100;
      else if (it == 1) cmd = 5'b00011;
      else begin
        case ($urandom_range(0, 2))
          0:       cmd = 5'(1 << $urandom_range(0, 4));
          1:       cmd = 5'b00000;
          default: cmd = 5'($urandom_range(0, 31));
        endcase
        chg_at = $urandom_range(10, 900);
      end
      exp = model_frame(cmd);
      do_reset(cmd, 1'b1);
      capture(20, -1, 1'b0, chg_at, 5'($urandom_range(0, 31)));
      checks++; if (cap_st !== 1) begin errors++; $display("[TB] FAIL decode_start cmd=%b: got %0d expected 1", cmd, cap_st); end
      checks++; if (cap_str != exp) begin errors++; $display("[TB] FAIL decode_text cmd=%b: got '%s' expected '%s'", cmd, vis(cap_str), vis(exp)); end
      checks++; if (cap_timing_ok !== 1'b1) begin errors++; $display("[TB] FAIL decode_bit_timing cmd=%b: got %b expected 1", cmd, cap_timing_ok); end
      checks++; if (cap_err_cnt !== model_err(cmd)) begin errors++; $display("[TB] FAIL decode_err_count cmd=%b: got %0d expected %0d", cmd, cap_err_cnt, model_err(cmd)); end
      checks++; if (cap_err_first !== 1'(model_err(cmd))) begin errors++; $display("[TB] FAIL decode_err_at_start cmd=%b: got %b expected %0d", cmd, cap_err_first, model_err(cmd)); end
    end
  endtask

  task automatic test_period();
    bit idle_ok;
    sel = 1'b0;
    do_reset(5'b00010, 1'b1);
    capture(20, -1, 1'b0, -1, 5'b0);
    checks++; if (cap_st !== 1) begin errors++; $display("[TB] FAIL period_first: got %0d expected 1", cap_st); end
    capture(1500, -1, 1'b0, -1, 5'b0);
    checks++; if (cap_st !== PERIOD + 1) begin errors++; $display("[TB] FAIL period_second: got %0d expected %0d", cap_st, PERIOD + 1); end
    capture(1500, -1, 1'b0, -1, 5'b0);
    checks++; if (cap_st !== 2 * PERIOD + 1) begin errors++; $display("[TB] FAIL period_third: got %0d expected %0d", cap_st, 2 * PERIOD + 1); end
    checks++; if (cap_str != model_frame(5'b00010)) begin errors++; $display("[TB] FAIL period_text: got '%s' expected '%s'", vis(cap_str), vis(model_frame(5'b00010))); end

    // tx_en low across the tick at cycle 2000: that tick is dropped.
    do_reset(5'b00010, 1'b1);
    capture(20, -1, 1'b0, -1, 5'b0);
    checks++; if (cap_st !== 1) begin errors++; $display("[TB] FAIL gate_first: got %0d expected 1", cap_st); end
    tx_en = 1'b0;
    wait_until(2500, idle_ok);
    checks++; if (idle_ok !== 1'b1) begin errors++; $display("[TB] FAIL gate_idle: got %b expected 1", idle_ok); end
    tx_en = 1'b1;
    capture(2000, -1, 1'b0, -1, 5'b0);
    checks++; if (cap_st !== 2 * PERIOD + 1) begin errors++; $display("[TB] FAIL gate_next: got %0d expected %0d", cap_st, 2 * PERIOD + 1); end
  endtask

  // 10-cycle period: ticks during frame 1 collapse into one follow-on frame.
  // With tx_en low during frame 2, its ticks are dropped, so the next frame
  // waits for the first tick after tx_en returns.
  task automatic test_back_to_back();
    bit idle_ok;
    sel = 1'b1;
    do_reset(5'b01000, 1'b1);
    capture(20, -1, 1'b0, -1, 5'b0);
    checks++; if (cap_st !== 1) begin errors++; $display("[TB] FAIL b2b_first: got %0d expected 1", cap_st); end
    checks++; if (cap_fd_end !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done1: got %b expected 1", cap_fd_end); end
    capture(5, 0, 1'b0, -1, 5'b0);
    checks++; if (cap_st !== FRAME_CYC + 2) begin errors++; $display("[TB] FAIL b2b_second: got %0d expected %0d", cap_st, FRAME_CYC + 2); end
    checks++; if (cap_str != model_frame(5'b01000)) begin errors++; $display("[TB] FAIL b2b_text: got '%s' expected '%s'", vis(cap_str), vis(model_frame(5'b01000))); end
    checks++; if (cap_fd_end !== 1'b1 || cap_busy_end !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done2: got done=%b busy=%b expected done=1 busy=0", cap_fd_end, cap_busy_end); end
    wait_until(2085, idle_ok);
    checks++; if (idle_ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_single_followon: got idle=%b expected 1", idle_ok); end
    tx_en = 1'b1;
    capture(40, -1, 1'b0, -1, 5'b0);
    checks++; if (cap_st !== 2091) begin errors++; $display("[TB] FAIL b2b_dropped_ticks: got %0d expected 2091", cap_st); end
    sel = 1'b0;
  endtask

  // Reset during byte 10. The line must return to idle on the next edge,
  // and a fresh full frame must follow the release.
  task automatic test_reset_midframe();
    bit idle_ok;
    sel = 1'b0;
    do_reset(5'b00001, 1'b1);
    wait_until(0, idle_ok);
    while ((cyc - rel0) < 404) @(negedge clk);
    checks++; if (uart_s !== 1'b0) begin errors++; $display("[TB] FAIL mid_byte10_start: got %b expected 0", uart_s); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (uart_s !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_uart: got %b expected 1", uart_s); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy_s); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rel0 = cyc;
    capture(20, -1, 1'b0, -1, 5'b0);
    checks++; if (cap_st !== 1) begin errors++; $display("[TB] FAIL mid_restart: got %0d expected 1", cap_st); end
    checks++; if (cap_str != model_frame(5'b00001)) begin errors++; $display("[TB] FAIL mid_restart_text: got '%s' expected '%s'", vis(cap_str), vis(model_frame(5'b00001))); end
  endtask

`ifdef MOTOR_TX_ONCHANGE_EN
  task automatic test_onchange();
    sel = 1'b0;
    do_reset(5'b00001, 1'b1);
    capture(20, -1, 1'b0, 100, 5'b01000);
    checks++; if (cap_str != model_frame(5'b00001)) begin errors++; $display("[TB] FAIL onchange_first_text: got '%s' expected '%s'", vis(cap_str), vis(model_frame(5'b00001))); end
    capture(5, -1, 1'b0, -1, 5'b0);
    checks++; if (cap_st !== FRAME_CYC + 2) begin errors++; $display("[TB] FAIL onchange_start: got %0d expected %0d", cap_st, FRAME_CYC + 2); end
    checks++; if (cap_str != model_frame(5'b01000)) begin errors++; $display("[TB] FAIL onchange_text: got '%s' expected '%s'", vis(cap_str), vis(model_frame(5'b01000))); end
  endtask
`endif

  initial begin
    $display("[TB] motor_json_tx bench start");
    test_reset();
    test_basic();
    test_decode();
    test_period();
    test_back_to_back();
    test_reset_midframe();
`ifdef MOTOR_TX_ONCHANGE_EN
    test_onchange();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
